// File: rtl/mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult_div_unit: EX-stage multi-cycle multiply/divide unit owning HI/LO.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MULT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] CNT_DIV  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  // Results are formed only from the latched operands.
  logic [63:0] prod_s, prod_u;
  logic        div_by_zero;
  logic [31:0] dvs, abs_a, abs_b, mag_q, mag_r, div_q, div_r, divu_q, divu_r;

  always_comb begin
    prod_s      = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u      = {32'd0, a_q} * {32'd0, b_q};
    div_by_zero = (b_q == 32'd0);
    dvs         = div_by_zero ? 32'd1 : b_q;
    divu_q      = a_q / dvs;
    divu_r      = a_q % dvs;
    // Magnitude division makes 0x80000000 / -1 fall out as 0x80000000 rem 0.
    abs_a       = a_q[31] ? (32'd0 - a_q) : a_q;
    abs_b       = dvs[31] ? (32'd0 - dvs) : dvs;
    mag_q       = abs_a / abs_b;
    mag_r       = abs_a % abs_b;
    div_q       = (a_q[31] ^ dvs[31]) ? (32'd0 - mag_q) : mag_q;
    div_r       = a_q[31] ? (32'd0 - mag_r) : mag_r;
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (busy_q) begin
      if (cnt_q == CNT_ONE) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        case (op_q)
          OP_MULT: begin
            hi_d = prod_s[63:32];
            lo_d = prod_s[31:0];
          end
          OP_MULTU: begin
            hi_d = prod_u[63:32];
            lo_d = prod_u[31:0];
          end
          OP_DIV: begin
            if (!div_by_zero) begin
              hi_d = div_r;
              lo_d = div_q;
            end
          end
          OP_DIVU: begin
            if (!div_by_zero) begin
              hi_d = divu_r;
              lo_d = divu_q;
            end
          end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (start) begin
      case (mdu_op)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          busy_d = 1'b1;
          op_d   = mdu_op;
          a_d    = rs_val;
          b_d    = rt_val;
          cnt_d  = ((mdu_op == OP_MULT) || (mdu_op == OP_MULTU)) ? CNT_MULT : CNT_DIV;
        end
        OP_MTHI: hi_d = rs_val;
        OP_MTLO: lo_d = rs_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= 3'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mult_div_unit: scoreboard bench for mult_div_unit with reference model. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdu_op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint      due;
    bit          chk_hl;
    bit          exp_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  longint      m_busy_end = -10;
  longint      m_done     = -10;

  function automatic void push(longint due, bit chk_hl, bit b, logic [31:0] h, logic [31:0] l,
                               string nm);
    chk_t e;
    e.due = due; e.chk_hl = chk_hl; e.exp_busy = b; e.exp_hi = h; e.exp_lo = l; e.name = nm;
    sb.push_back(e);
  endfunction

  // Architectural result of an op, straight from the MIPS arithmetic rules.
  function automatic void model_exec(input logic [2:0] op, input logic [31:0] a, b,
                                     input logic [31:0] h_in, l_in,
                                     output logic [31:0] h, output logic [31:0] l);
    longint          p;
    longint unsigned pu;
    int              q, r;
    h = h_in; l = l_in;
    case (op)
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); h = p[63:32]; l = p[31:0]; end
      3'd2: begin pu = {32'd0, a} * {32'd0, b}; h = pu[63:32]; l = pu[31:0]; end
      3'd3: if (b != 32'd0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = 32'd0;
        end else begin
          q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
          l = q; h = r;
        end
      end
      3'd4: if (b != 32'd0) begin l = a / b; h = a % b; end
      default: ;
    endcase
  endfunction

  // Monitor: compare every check due in the cycle just completed.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        n_checks++;
        if (busy !== sb[i].exp_busy ||
            (sb[i].chk_hl && (hi !== sb[i].exp_hi || lo !== sb[i].exp_lo))) begin
          n_fail++;
          $display("FAIL %s cyc=%0d: got busy=%b hi=%h lo=%h, expected busy=%b hi=%h lo=%h (hi/lo checked=%0b)",
                   sb[i].name, cyc, busy, hi, lo, sb[i].exp_busy, sb[i].exp_hi, sb[i].exp_lo,
                   sb[i].chk_hl);
        end
        sb.delete(i);
      end
    end
  end

  // Drives a start pulse; the caller must follow with another issue or release_start.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, input string nm,
                       output longint done);
    longint      e, n;
    logic [31:0] nh, nl;
    @(posedge clk); #1;
    start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    e = cyc + 1;
    done = e;
    if (e - 1 <= m_busy_end) begin
      push(e, (e > m_busy_end), (e <= m_busy_end), m_hi, m_lo, {nm, " ignored"});
    end else begin
      case (op)
        3'd1, 3'd2, 3'd3, 3'd4: begin
          n = (op <= 3'd2) ? MC : DC;
          push(e, 1'b1, 1'b1, m_hi, m_lo, {nm, " busy first"});
          push(e + n - 1, 1'b1, 1'b1, m_hi, m_lo, {nm, " busy last"});
          model_exec(op, a, b, m_hi, m_lo, nh, nl);
          m_hi = nh; m_lo = nl;
          push(e + n, 1'b1, 1'b0, m_hi, m_lo, {nm, " result"});
          m_busy_end = e + n - 1;
          m_done     = e + n;
          done       = e + n;
        end
        3'd5: begin m_hi = a; push(e, 1'b1, 1'b0, m_hi, m_lo, {nm, " mthi"}); end
        3'd6: begin m_lo = a; push(e, 1'b1, 1'b0, m_hi, m_lo, {nm, " mtlo"}); end
        default: push(e, 1'b1, 1'b0, m_hi, m_lo, {nm, " nop"});
      endcase
    end
  endtask

  task automatic release_start();
    @(posedge clk); #1;
    start  = 1'b0;
    mdu_op = 3'($urandom_range(0, 7));
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  task automatic do_reset(input int ncyc);
    longint r;
    @(posedge clk); #1;
    reset = 1'b1;
    r = cyc + 1;
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due >= r) sb.delete(i);
    push(r, 1'b1, 1'b0, 32'd0, 32'd0, "reset clears");
    if (m_done >= r + ncyc) push(m_done, 1'b1, 1'b0, 32'd0, 32'd0, "aborted op not written");
    m_hi = 32'd0; m_lo = 32'd0; m_busy_end = -10; m_done = -10;
    repeat (ncyc) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (cyc <= m_done && guard < 100) begin @(posedge clk); guard++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    longint d;
    logic [2:0]  op;
    logic [31:0] a, b;
    int guard;

    do_reset(2);

    issue(3'd1, 32'hFFFF_FFFE, 32'd3, "t1 mult", d); release_start();
    push(d, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "t1 mult const");
    wait_done();

    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2 multu", d); release_start();
    push(d, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, "t2 multu const");
    wait_done();

    issue(3'd3, 32'hFFFF_FFF9, 32'd2, "t3 div", d); release_start();
    push(d, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "t3 div const");
    wait_done();
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, "t3 divu", d); release_start();
    push(d, 1'b1, 1'b0, 32'h0000_0001, 32'h7FFF_FFFC, "t3 divu const");
    wait_done();

    issue(3'd5, 32'h1234_5678, 32'd0, "t4 mthi", d);
    push(d, 1'b0, 1'b0, 32'd0, 32'd0, "t4 mthi no busy");
    issue(3'd6, 32'h9ABC_DEF0, 32'd0, "t4 mtlo", d); release_start();
    push(d, 1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, "t4 mt const");
    issue(3'd3, 32'd77, 32'd0, "t4 div0", d); release_start();
    push(d, 1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, "t4 div0 keeps");
    wait_done();

    issue(3'd3, 32'd100, 32'd7, "t5 div", d); release_start();
    push(d, 1'b1, 1'b0, 32'd2, 32'd14, "t5 div const");
    repeat (1) @(posedge clk);
    issue(3'd1, 32'd5, 32'd5, "t5 mult while busy", d); release_start();
    wait_done();
    repeat (2) @(posedge clk);
    issue(3'd1, 32'd5, 32'd5, "t5 mult after", d); release_start();
    push(d, 1'b1, 1'b0, 32'd0, 32'd25, "t5 mult const");
    wait_done();

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "ovf div", d); release_start();
    push(d, 1'b1, 1'b0, 32'd0, 32'h8000_0000, "ovf div const");
    wait_done();

    issue(3'd1, 32'h0000_1234, 32'h0000_5678, "t6 mult", d);
    release_start();
    do_reset(1);
    wait_done();
    repeat (MC + 2) @(posedge clk);

    for (int k = 0; k < 80; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      issue(op, a, b, "rand", d);
      release_start();
      if ($urandom_range(0, 24) == 0) do_reset(1);
      repeat ($urandom_range(0, 12)) @(posedge clk);
    end

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin @(posedge clk); guard++; end
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d checks pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
